// File: rtl/instruction_loader.sv
// Instruction loader: assembles a little-endian byte stream into 16-bit words,
// writes them to instruction memory and holds the CPU in reset-like stall until
// the program is loaded (terminator word 16'hFFFF or memory full).
// Optional feature macro: LOADER_CHECKSUM_EN -- after the terminator a 16-bit
// checksum word (XOR of all written words, low byte first) is received and
// compared; a mismatch raises cksum_err.
// Ports:
//   clk, rst_n                 clock, async active-low reset
//   start                      one-cycle pulse requesting a (re)load
//   byte_in/byte_valid         incoming program byte stream
//   byte_ready                 loader accepts byte_in this cycle
//   im_we/im_addr/im_wdata     instruction-memory write port
//   cpu_hold                   stalls the CPU, PC held at 0
//   load_done/full/cksum_err   load status levels
module instruction_loader #(
  parameter int unsigned ADDR_W = 6
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [7:0]  byte_in,
  input  logic        byte_valid,
  output logic        byte_ready,
  output logic        im_we,
  output logic [15:0] im_addr,
  output logic [15:0] im_wdata,
  output logic        cpu_hold,
  output logic        load_done,
  output logic        full,
  output logic        cksum_err
);

  localparam int unsigned WORD_W = 16;
  localparam logic [ADDR_W-1:0] CNT_MAX = '1;
  localparam logic [WORD_W-1:0] TERM_WORD = 16'hFFFF;

  typedef enum logic [2:0] {IDLE, LO, HI, WRITE, DONE, CHK_LO, CHK_HI} state_t;

`ifdef LOADER_CHECKSUM_EN
  localparam state_t TERM_NEXT = CHK_LO;
`else
  localparam state_t TERM_NEXT = DONE;
`endif

  state_t              state;
  state_t              state_n;
  logic [ADDR_W-1:0]   cnt;
  logic [7:0]          lo_byte;
  logic                xfer;
  logic                accept_start;
  logic                ready_n;
  logic [WORD_W-1:0]   hi_word;

  // Handshake and the word completed by the byte currently on the bus
  assign xfer         = byte_valid & byte_ready;
  assign accept_start = start & ((state == IDLE) | (state == DONE));
  assign hi_word      = {byte_in, lo_byte};

  // Next-state logic
  always_comb begin
    state_n = state;
    case (state)
      IDLE:    if (start) state_n = LO;
      LO:      if (xfer) state_n = HI;
      HI:      if (xfer) state_n = (hi_word == TERM_WORD) ? TERM_NEXT : WRITE;
      WRITE:   state_n = (cnt == CNT_MAX) ? DONE : LO;
      DONE:    if (start) state_n = LO;
`ifdef LOADER_CHECKSUM_EN
      CHK_LO:  if (xfer) state_n = CHK_HI;
      CHK_HI:  if (xfer) state_n = DONE;
`endif
      default: state_n = IDLE;
    endcase
  end

  // byte_ready is registered, so it is derived from the state being entered
  always_comb begin
    ready_n = (state_n == LO) | (state_n == HI);
`ifdef LOADER_CHECKSUM_EN
    ready_n = ready_n | (state_n == CHK_LO) | (state_n == CHK_HI);
`endif
  end

  // State, datapath and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      cnt        <= '0;
      lo_byte    <= '0;
      im_we      <= 1'b0;
      im_addr    <= '0;
      im_wdata   <= '0;
      byte_ready <= 1'b0;
      cpu_hold   <= 1'b1;
      load_done  <= 1'b0;
      full       <= 1'b0;
    end else begin
      state      <= state_n;
      byte_ready <= ready_n;
      cpu_hold   <= (state_n != DONE);
      load_done  <= (state_n == DONE);
      im_we      <= (state_n == WRITE);

      if (accept_start) begin
        cnt  <= '0;
        full <= 1'b0;
      end

      if (xfer && ((state == LO) || (state == CHK_LO))) lo_byte <= byte_in;

      // Write port is loaded only for real words; it holds otherwise
      if (xfer && (state == HI) && (hi_word != TERM_WORD)) begin
        im_addr  <= WORD_W'(cnt);
        im_wdata <= hi_word;
      end

      // Counter saturates at the last word instead of wrapping
      if (state == WRITE) begin
        if (cnt == CNT_MAX) full <= 1'b1;
        else                cnt  <= cnt + ADDR_W'(1);
      end
    end
  end

`ifdef LOADER_CHECKSUM_EN
  logic [WORD_W-1:0] acc;

  // XOR accumulator of written words and the checksum compare
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc       <= '0;
      cksum_err <= 1'b0;
    end else begin
      if (accept_start) begin
        acc       <= '0;
        cksum_err <= 1'b0;
      end else if (state == WRITE) begin
        acc <= acc ^ im_wdata;
      end
      if (xfer && (state == CHK_HI)) cksum_err <= (hi_word != acc);
    end
  end
`else
  assign cksum_err = 1'b0;
`endif

endmodule

// File: tb/tb_instruction_loader.sv
module tb_instruction_loader;

  localparam int unsigned ADDR_W = 2;
  localparam int unsigned TMO    = 50;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [7:0]  byte_in;
  logic        byte_valid;
  logic        byte_ready;
  logic        im_we;
  logic [15:0] im_addr;
  logic [15:0] im_wdata;
  logic        cpu_hold;
  logic        load_done;
  logic        full;
  logic        cksum_err;

  int n_cmp = 0;
  int n_err = 0;

  logic [31:0] exp_q[$];
  logic [15:0] m_addr;
  logic [15:0] m_sum;

  instruction_loader #(.ADDR_W(ADDR_W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .byte_in    (byte_in),
    .byte_valid (byte_valid),
    .byte_ready (byte_ready),
    .im_we      (im_we),
    .im_addr    (im_addr),
    .im_wdata   (im_wdata),
    .cpu_hold   (cpu_hold),
    .load_done  (load_done),
    .full       (full),
    .cksum_err  (cksum_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Scoreboard: every write strobe must match the oldest expected write
  always @(negedge clk) begin
    if (im_we) begin
      if (exp_q.size() == 0) begin
        check("unexpected_we", {im_addr, im_wdata}, 32'hDEAD_DEAD);
      end else begin
        check("im_write", {im_addr, im_wdata}, exp_q.pop_front());
      end
    end
  end

  // Called at a negedge; returns at the negedge after the byte was taken
  task automatic send_byte(input logic [7:0] b, input bit toggle);
    int n = 0;
    if (toggle) begin
      byte_valid = 1'b0;
      @(negedge clk);
    end
    byte_in    = b;
    byte_valid = 1'b1;
    while (!byte_ready && n < TMO) begin
      @(negedge clk);
      n++;
    end
    if (n >= TMO) check("ready_timeout", 32'(byte_ready), 32'd1);
    @(negedge clk);
    byte_valid = 1'b0;
  endtask

  task automatic send_word(input logic [15:0] w, input bit toggle);
    exp_q.push_back({m_addr, w});
    m_addr = m_addr + 16'd1;
    m_sum  = m_sum ^ w;
    send_byte(w[7:0], toggle);
    send_byte(w[15:8], toggle);
  endtask

  // Terminator, followed by the model checksum when that feature is built in
  task automatic send_term(input bit toggle);
    send_byte(8'hFF, toggle);
    send_byte(8'hFF, toggle);
`ifdef LOADER_CHECKSUM_EN
    send_byte(m_sum[7:0], toggle);
    send_byte(m_sum[15:8], toggle);
`endif
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    m_addr = '0;
    m_sum  = '0;
  endtask

  task automatic check_done(input string tag, input logic exp_full);
    check({tag, "_load_done"}, 32'(load_done), 32'd1);
    check({tag, "_cpu_hold"}, 32'(cpu_hold), 32'd0);
    check({tag, "_full"}, 32'(full), 32'(exp_full));
    check({tag, "_ready"}, 32'(byte_ready), 32'd0);
    check({tag, "_cksum_err"}, 32'(cksum_err), 32'd0);
  endtask

  initial begin
    rst_n      = 1'b0;
    start      = 1'b0;
    byte_in    = '0;
    byte_valid = 1'b0;
    m_addr     = '0;
    m_sum      = '0;
    repeat (3) @(negedge clk);

    // Reset state
    check("rst_ready", 32'(byte_ready), 32'd0);
    check("rst_hold", 32'(cpu_hold), 32'd1);
    check("rst_done", 32'(load_done), 32'd0);
    check("rst_full", 32'(full), 32'd0);
    check("rst_cksum", 32'(cksum_err), 32'd0);
    check("rst_port", {15'd0, im_we, im_addr}, 32'd0);
    check("rst_wdata", 32'(im_wdata), 32'd0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    check("idle_ready", 32'(byte_ready), 32'd0);

    // Basic two-word load
    pulse_start();
    check("lo_ready", 32'(byte_ready), 32'd1);
    check("lo_hold", 32'(cpu_hold), 32'd1);
    send_word(16'h1234, 1'b0);
    check("we_latency", 32'(im_we), 32'd1);
    send_word(16'hABCD, 1'b0);
    send_term(1'b0);
    check("done_latency", 32'(load_done), 32'd1);
    @(negedge clk);
    check_done("basic", 1'b0);
    check("hold_port", {im_addr, im_wdata}, {16'd1, 16'hABCD});

    // Reload from DONE with byte_valid toggling every cycle
    pulse_start();
    check("reload_hold", 32'(cpu_hold), 32'd1);
    check("reload_done", 32'(load_done), 32'd0);
    send_word(16'h1234, 1'b1);
    send_word(16'hABCD, 1'b1);
    send_term(1'b1);
    @(negedge clk);
    check_done("toggle", 1'b0);

    // Fill every word: ends on full with no terminator
    pulse_start();
    send_word(16'h1111, 1'b0);
    send_word(16'h2222, 1'b0);
    send_word(16'h3333, 1'b1);
    send_word(16'h4444, 1'b0);
    check("full_last_we", 32'(im_we), 32'd1);
    @(negedge clk);
    check_done("full", 1'b1);
    check("full_port", {im_addr, im_wdata}, {16'd3, 16'h4444});
    repeat (3) @(negedge clk);
    check("full_stays_ready0", 32'(byte_ready), 32'd0);

    // Reset in the middle of a load
    pulse_start();
    check("full_cleared", 32'(full), 32'd0);
    send_byte(8'h34, 1'b0);
    rst_n = 1'b0;
    #1;
    check("abort_hold", 32'(cpu_hold), 32'd1);
    check("abort_ready", 32'(byte_ready), 32'd0);
    check("abort_we", 32'(im_we), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    check("abort_idle", {30'd0, byte_ready, cpu_hold}, 32'd1);
    pulse_start();
    send_word(16'h5678, 1'b0);
    send_term(1'b0);
    @(negedge clk);
    check_done("after_abort", 1'b0);

    // start while in HI is ignored
    pulse_start();
    exp_q.push_back({16'd0, 16'h1234});
    m_addr = 16'd1;
    m_sum  = 16'h1234;
    send_byte(8'h34, 1'b0);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    send_byte(8'h12, 1'b0);
    send_word(16'hABCD, 1'b0);
    send_term(1'b0);
    @(negedge clk);
    check_done("start_in_hi", 1'b0);
    check("start_in_hi_port", {im_addr, im_wdata}, {16'd1, 16'hABCD});

`ifdef LOADER_CHECKSUM_EN
    // Explicit good checksum, then a bad one
    pulse_start();
    send_word(16'h1234, 1'b0);
    send_word(16'hABCD, 1'b0);
    send_byte(8'hFF, 1'b0);
    send_byte(8'hFF, 1'b0);
    check("chk_wait_done", 32'(load_done), 32'd0);
    send_byte(8'hF9, 1'b0);
    send_byte(8'hB9, 1'b0);
    check("chk_good_err", 32'(cksum_err), 32'd0);
    check("chk_good_done", 32'(load_done), 32'd1);
    pulse_start();
    send_word(16'h1234, 1'b0);
    send_word(16'hABCD, 1'b0);
    send_byte(8'hFF, 1'b0);
    send_byte(8'hFF, 1'b0);
    send_byte(8'h00, 1'b0);
    send_byte(8'h00, 1'b0);
    check("chk_bad_err", 32'(cksum_err), 32'd1);
    check("chk_bad_done", 32'(load_done), 32'd1);
    pulse_start();
    check("chk_err_cleared", 32'(cksum_err), 32'd0);
    send_term(1'b0);
`endif

    repeat (3) @(negedge clk);
    check("sb_drained", 32'(exp_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
